mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the five-stage pipeline, between the EX/MEM pipeline register and MEM_WB. It turns load/store requests from EX/MEM into a req/ack handshake on the data-memory port. It aligns and extends load data, and stalls the front of the pipeline while an access is outstanding. It produces the ReadData_, ALU_Result_, Write_Destination_ and WB values that MEM_WB captures.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_access_stage_if.sv | 27 ++
 rtl/load_align.sv | 38 +++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared encodings for the MEM stage, MEM_WB and write-back mux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << addr_lo;
      SZ_HALF: byte_enables = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane sees the same value.
  function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                 input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_replicate = {4{data[7:0]}};
      SZ_HALF: lane_replicate = {2{data[15:0]}};
      default: lane_replicate = data;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if : req/ack data-memory port of the MEM stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align : picks the addressed lane from a read word and extends it
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage : MEM pipeline stage, req/ack data port with stall/timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_stage
  import mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_dest,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  wb_in,
  output logic        stall,
  output logic [31:0] ReadData_,
  output logic [31:0] ALU_Result_,
  output logic [4:0]  Write_Destination_,
  output logic [1:0]  WB,
  output logic        misalign,
  output logic        bus_error,
  mem_access_stage_if.master mem
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        timed_out;
  logic [31:0] rdata_q;
  logic [1:0]  lat_addr_lo;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_read;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        access;
  logic        is_write;
  logic        aligned;
  logic        start;
  logic [31:0] load_data;

  // Both read and write set is treated as a read.
  assign access   = in_valid & (mem_read | mem_write);
  assign is_write = mem_write & ~mem_read;

  always_comb begin
    case (mem_size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~alu_result[0];
      default: aligned = (alu_result[1:0] == 2'b00);
    endcase
  end

  assign start     = (state == ST_IDLE) & access & aligned;
  assign stall     = start | (state == ST_BUSY);
  assign misalign  = (state == ST_IDLE) & access & ~aligned;
  assign bus_error = (state == ST_DONE) & timed_out;

  assign ReadData_          = (state == ST_DONE) ? rdata_q : 32'd0;
  assign ALU_Result_        = alu_result;
  assign Write_Destination_ = write_dest;
  assign WB                 = (misalign | bus_error) ? 2'b00 : wb_in;

  load_align u_load_align (
    .addr_lo     (lat_addr_lo),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .rdata       (mem.mem_rdata),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
      rdata_q      <= '0;
      lat_addr_lo  <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_read     <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_BUSY;
            req_q        <= 1'b1;
            we_q         <= is_write;
            addr_q       <= {alu_result[31:2], 2'b00};
            wdata_q      <= lane_replicate(mem_size, write_data);
            be_q         <= byte_enables(mem_size, alu_result[1:0]);
            wait_cnt     <= '0;
            timed_out    <= 1'b0;
            lat_addr_lo  <= alu_result[1:0];
            lat_size     <= mem_size;
            lat_unsigned <= mem_unsigned;
            lat_read     <= mem_read;
          end
        end
        ST_BUSY: begin
          // An ack on the limit edge still completes the access.
          if (mem.mem_ack) begin
            state   <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= lat_read ? load_data : 32'd0;
          end else if (wait_cnt == LIMIT) begin
            state     <= ST_DONE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            timed_out <= 1'b1;
            rdata_q   <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage : randomized transaction-level check of the MEM stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;

  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  write_dest;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  wb_in;
  logic        stall;
  logic [31:0] ReadData_;
  logic [31:0] ALU_Result_;
  logic [4:0]  Write_Destination_;
  logic [1:0]  WB;
  logic        misalign;
  logic        bus_error;

  mem_access_stage_if mem_bus();

  mem_access_stage #(.WAIT_LIMIT(WL)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .alu_result         (alu_result),
    .write_data         (write_data),
    .write_dest         (write_dest),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_size           (mem_size),
    .mem_unsigned       (mem_unsigned),
    .wb_in              (wb_in),
    .stall              (stall),
    .ReadData_          (ReadData_),
    .ALU_Result_        (ALU_Result_),
    .Write_Destination_ (Write_Destination_),
    .WB                 (WB),
    .misalign           (misalign),
    .bus_error          (bus_error),
    .mem                (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, req, mis, berr;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  dest;
    bit          rd_chk;
    logic [31:0] rd;
    bit          bus_chk;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    bit          lit_rd_en;
    logic [31:0] lit_rd;
    bit          lit_bus_en;
    logic [3:0]  lit_be;
    logic [31:0] lit_wd;
  } cyc_t;

  typedef struct {
    logic        v, rd, wr, uns;
    logic [1:0]  sz, wb;
    logic [31:0] a, wd;
    logic [4:0]  dest;
  } ins_t;

  cyc_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
    int lane = int'(a[1:0]);
    return (lane % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n    = nbytes(sz);
    int lane = int'(a[1:0]);
    int m    = ((1 << n) - 1) << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] o;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] rdata);
    int          n    = nbytes(sz);
    int          lane = int'(a[1:0]);
    logic [31:0] v, mask;
    if (n == 4) return rdata;
    v    = rdata >> (8 * lane);
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    cyc_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("mem_req", 32'(mem_bus.mem_req), 32'(e.req));
      chk("misalign", 32'(misalign), 32'(e.mis));
      chk("bus_error", 32'(bus_error), 32'(e.berr));
      chk("WB", 32'(WB), 32'(e.wb));
      chk("ALU_Result_", ALU_Result_, e.alu);
      chk("Write_Destination_", 32'(Write_Destination_), 32'(e.dest));
      if (e.rd_chk) chk("ReadData_", ReadData_, e.rd);
      if (e.bus_chk) begin
        chk("mem_we", 32'(mem_bus.mem_we), 32'(e.we));
        chk("mem_addr", mem_bus.mem_addr, e.addr);
        chk("mem_wdata", mem_bus.mem_wdata, e.wdata);
        chk("mem_be", 32'(mem_bus.mem_be), 32'(e.be));
      end
      if (e.lit_rd_en) chk("lit_ReadData_", ReadData_, e.lit_rd);
      if (e.lit_bus_en) begin
        chk("lit_mem_be", 32'(mem_bus.mem_be), 32'(e.lit_be));
        chk("lit_mem_wdata", mem_bus.mem_wdata, e.lit_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle(input cyc_t e, input logic ack, input logic [31:0] rdat);
    mem_bus.mem_ack   = ack;
    mem_bus.mem_rdata = rdat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic cyc_t base_rec(input ins_t t);
    cyc_t e;
    e = '{default: '0};
    e.wb   = t.wb;
    e.alu  = t.a;
    e.dest = t.dest;
    return e;
  endfunction

  task automatic apply(input ins_t t);
    in_valid     = t.v;
    mem_read     = t.rd;
    mem_write    = t.wr;
    mem_size     = t.sz;
    mem_unsigned = t.uns;
    alu_result   = t.a;
    write_data   = t.wd;
    write_dest   = t.dest;
    wb_in        = t.wb;
  endtask

  // lat = BUSY cycle index carrying ack; lat > WL means ack never comes.
  task automatic run_instr(input ins_t t, input int lat, input logic [31:0] ack_rdata,
                           input bit lit_rd_en, input logic [31:0] lit_rd,
                           input bit lit_bus_en, input logic [3:0] lit_be,
                           input logic [31:0] lit_wd);
    cyc_t        e;
    logic [31:0] captured;
    bit          acc;
    int          n_busy;
    acc = t.v && (t.rd || t.wr);
    apply(t);
    e = base_rec(t);
    if (!acc) begin
      e.rd_chk = 1;
      e.rd     = 32'd0;
      drive_cycle(e, 1'($urandom_range(0, 1)), $urandom);
      return;
    end
    if (!m_aligned(t.sz, t.a)) begin
      e.mis = 1;
      e.wb  = 2'b00;
      drive_cycle(e, 1'($urandom_range(0, 1)), $urandom);
      return;
    end
    e.stall = 1;
    drive_cycle(e, 1'($urandom_range(0, 1)), $urandom);
    n_busy   = (lat <= WL) ? lat + 1 : WL + 1;
    captured = 32'd0;
    for (int i = 0; i < n_busy; i++) begin
      e            = base_rec(t);
      e.stall      = 1;
      e.req        = 1;
      e.bus_chk    = 1;
      e.we         = t.wr & ~t.rd;
      e.addr       = {t.a[31:2], 2'b00};
      e.wdata      = m_wdata(t.sz, t.wd);
      e.be         = m_be(t.sz, t.a);
      e.lit_bus_en = lit_bus_en;
      e.lit_be     = lit_be;
      e.lit_wd     = lit_wd;
      if (i == lat) begin
        captured = ack_rdata;
        drive_cycle(e, 1'b1, ack_rdata);
      end else begin
        drive_cycle(e, 1'b0, $urandom);
      end
    end
    e = base_rec(t);
    if (lat > WL) begin
      e.berr = 1;
      e.wb   = 2'b00;
    end else if (t.rd) begin
      e.rd_chk    = 1;
      e.rd        = m_load(t.sz, t.a, t.uns, captured);
      e.lit_rd_en = lit_rd_en;
      e.lit_rd    = lit_rd;
    end
    drive_cycle(e, 1'($urandom_range(0, 1)), $urandom);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1);
  end

  initial begin : stim
    ins_t t;
    cyc_t e;
    int   r, lat;
    reset = 1'b1;
    t = '{default: '0};
    apply(t);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    @(posedge clk);
    #1;
    // Reset state: bus registers cleared, nothing stalled.
    e = base_rec(t);
    e.bus_chk = 1;
    e.rd_chk  = 1;
    drive_cycle(e, 1'b0, 32'd0);
    drive_cycle(e, 1'b1, 32'd0);
    reset = 1'b0;

    // lw 0x100 -> 0xDEADBEEF
    t = '{v:1, rd:1, wr:0, uns:0, sz:2'd2, wb:2'b11, a:32'h100, wd:32'd0, dest:5'd8};
    run_instr(t, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 4'd0, 32'd0);
    // lb / lbu at 0x103
    t = '{v:1, rd:1, wr:0, uns:0, sz:2'd0, wb:2'b11, a:32'h103, wd:32'd0, dest:5'd9};
    run_instr(t, 1, 32'h80FFFF7F, 1, 32'hFFFFFF80, 0, 4'd0, 32'd0);
    t.uns = 1;
    run_instr(t, 0, 32'h80FFFF7F, 1, 32'h00000080, 0, 4'd0, 32'd0);
    // sh at 0x102
    t = '{v:1, rd:0, wr:1, uns:0, sz:2'd1, wb:2'b00, a:32'h102, wd:32'h0000ABCD, dest:5'd0};
    run_instr(t, 2, 32'd0, 0, 32'd0, 1, 4'b1100, 32'hABCDABCD);
    // misaligned lw at 0x101
    t = '{v:1, rd:1, wr:0, uns:0, sz:2'd2, wb:2'b11, a:32'h101, wd:32'd0, dest:5'd3};
    run_instr(t, 0, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0);
    // timeout, ack never asserted
    t = '{v:1, rd:1, wr:0, uns:0, sz:2'd2, wb:2'b11, a:32'h200, wd:32'd0, dest:5'd4};
    run_instr(t, WL + 1, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0);

    // reset in the middle of BUSY, then a late ack
    t = '{v:1, rd:1, wr:0, uns:0, sz:2'd2, wb:2'b11, a:32'h300, wd:32'd0, dest:5'd5};
    apply(t);
    e = base_rec(t);
    e.stall = 1;
    drive_cycle(e, 1'b0, 32'd0);
    e.req = 1;
    drive_cycle(e, 1'b0, 32'd0);
    reset = 1'b1;
    drive_cycle(e, 1'b0, 32'd0);
    reset = 1'b0;
    t.v = 0;
    t.rd = 0;
    apply(t);
    e = base_rec(t);
    e.rd_chk  = 1;
    e.bus_chk = 1;
    drive_cycle(e, 1'b1, 32'h12345678);
    e.bus_chk = 0;
    drive_cycle(e, 1'b0, 32'd0);

    // randomized back-to-back traffic
    for (int k = 0; k < 300; k++) begin
      r      = $urandom_range(0, 19);
      t.v    = ($urandom_range(0, 9) != 0);
      t.rd   = (r <= 8) || (r == 16);
      t.wr   = (r >= 9 && r <= 16);
      t.uns  = 1'($urandom_range(0, 1));
      t.sz   = 2'($urandom_range(0, 3));
      t.wb   = 2'($urandom_range(0, 3));
      t.a    = $urandom;
      t.wd   = $urandom;
      t.dest = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (t.sz == 2'd1) t.a[0] = 1'b0;
        if (t.sz >= 2'd2) t.a[1:0] = 2'b00;
      end
      lat = ($urandom_range(0, 7) == 0) ? WL + 1 : $urandom_range(0, WL);
      run_instr(t, lat, $urandom, 0, 32'd0, 0, 4'd0, 32'd0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
